// File: rtl/uart_rx_mmio_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// CPU-visible addresses and the status-word packing used by the load mux.
package uart_rx_mmio_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Mirror of the define.v entries used by the CPU load/store decode
  localparam logic [31:0] UART_RX_DATA_ADDR = 32'h0000_FF10;
  localparam logic [31:0] UART_RX_STAT_ADDR = 32'h0000_FF14;

  function automatic logic [31:0] rx_status(input logic frame_err,
                                            input logic overrun,
                                            input logic rx_valid);
    return {29'b0, frame_err, overrun, rx_valid};
  endfunction

endpackage

// File: rtl/uart_rx_mmio_fifo.sv
// Small show-ahead byte FIFO; pushes while full and pops while empty are ignored.
module rx_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is only observable through count, so it needs no reset
  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver feeding a byte FIFO, with sticky overrun/framing flags
// for memory-mapped status reads.
module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1085,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_q;
  logic          rxs;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          armed_q, armed_d;
  logic          overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic          fifo_push, fifo_full, fifo_empty, ovr_set, fe_set;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], uart_rx};
  end
  assign rxs = sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    fifo_push = 1'b0;
    ovr_set   = 1'b0;
    fe_set    = 1'b0;
    case (state_q)
      // armed_q keeps a held-low (break) line from retriggering a frame
      RX_IDLE: begin
        if (!armed_q) armed_d = rxs;
        else if (!rxs) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d   = RX_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = RX_IDLE;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      RX_DATA: begin
        if (cnt_q == BIT_M1) begin
          shift_d[bit_idx_q] = rxs;
          cnt_d              = '0;
          bit_idx_d          = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
        end else cnt_d = cnt_q + 1'b1;
      end
      RX_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          armed_d = 1'b0;
          if (!rxs)          fe_set    = 1'b1;
          else if (fifo_full) ovr_set  = 1'b1;
          else               fifo_push = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = RX_IDLE;
    endcase
    // A new error event in the clearing cycle still sets the flag
    overrun_d   = (overrun_q   && !clr_err) || ovr_set;
    frame_err_d = (frame_err_q && !clr_err) || fe_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  rx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (rd_en),
    .din   (shift_d),
    .dout  (rd_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rx_valid  = !fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Drives 8N1 frames into uart_rx_mmio and compares every cycle against a
// queue-based receive model; directed scenarios add literal expectations.
module tb_uart_rx_mmio;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  // Edges from the first low start-bit sample to the stop-bit sample:
  // two synchronizer stages, half a bit to mid-start, 8 data bits, stop bit.
  localparam int LAT = 2 + CPB/2 + 9*CPB;

  logic       clk = 1'b0, rst = 1'b1, uart_rx = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rx_valid, overrun, frame_err;

  uart_rx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data), .rx_valid(rx_valid), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {int at; logic [7:0] d; logic stop;} ev_t;
  ev_t        pend[$];
  logic [7:0] mq[$];
  logic       m_ovr = 1'b0, m_fe = 1'b0;
  int         n_chk = 0, n_fail = 0, cyc = 0;
  bit         chk_on = 1'b0, rnd_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Receive model: a frame's byte lands (or is dropped) at its stop-sample edge
  ev_t ev;
  bit  have_ev, was_full;
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete(); pend.delete();
      m_ovr = 1'b0; m_fe = 1'b0;
    end else begin
      have_ev = 1'b0;
      if (pend.size() != 0 && pend[0].at == cyc) begin
        ev = pend.pop_front();
        have_ev = 1'b1;
      end
      was_full = (mq.size() == DEPTH);
      if (clr_err) begin m_ovr = 1'b0; m_fe = 1'b0; end
      if (rd_en && mq.size() != 0) void'(mq.pop_front());
      if (have_ev) begin
        if (!ev.stop)     m_fe = 1'b1;
        else if (was_full) m_ovr = 1'b1;
        else              mq.push_back(ev.d);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rx_valid", rx_valid, mq.size() != 0);
      chk("rd_data", rd_data, mq.size() != 0 ? mq[0] : 8'h00);
      chk("overrun", overrun, m_ovr);
      chk("frame_err", frame_err, m_fe);
    end
  end

  always @(negedge clk) begin
    if (rnd_on) begin
      rd_en   = ($urandom_range(0, 15) == 0);
      clr_err = ($urandom_range(0, 31) == 0);
    end
  end

  // Called at a negedge; returns at the negedge ending the stop bit
  task automatic send_frame(input logic [7:0] b, input logic stop, input int hold_low);
    ev_t e;
    e.at = cyc + 1 + LAT; e.d = b; e.stop = stop;
    pend.push_back(e);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    if (!stop) repeat (hold_low) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    chk(name, rd_data, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  logic [7:0] t2_bytes [5] = '{8'hA3, 8'h00, 8'hFF, 8'h7E, 8'h12};
  logic [7:0] ab;
  int         pe;
  logic [7:0] rb;
  logic       rs;

  initial begin
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("reset rx_valid", rx_valid, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset overrun", overrun, 0);
    chk("reset frame_err", frame_err, 0);
    rst = 1'b0;
    idle(5);

    // Single frame and push latency
    pe = cyc + 1 + LAT;
    fork
      send_frame(8'h55, 1'b1, 0);
      begin
        wait_cyc(pe - 1); chk("t1 before push", rx_valid, 0);
        wait_cyc(pe);     chk("t1 after push", rx_valid, 1);
        chk("t1 data", rd_data, 8'h55);
      end
    join
    rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
    chk("t1 popped valid", rx_valid, 0);
    chk("t1 popped data", rd_data, 0);
    idle(4);

    // Fill, overflow, drain
    for (int i = 0; i < 5; i++) send_frame(t2_bytes[i], 1'b1, 0);
    idle(2);
    chk("t2 overrun", overrun, 1);
    pop_chk("t2 pop0", 8'hA3);
    pop_chk("t2 pop1", 8'h00);
    pop_chk("t2 pop2", 8'hFF);
    pop_chk("t2 pop3", 8'h7E);
    chk("t2 empty", rx_valid, 0);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("t2 overrun cleared", overrun, 0);

    // Start-bit glitch
    uart_rx = 1'b0; repeat (3) @(negedge clk);
    idle(20);
    chk("t3 glitch no push", rx_valid, 0);
    send_frame(8'h81, 1'b1, 0);
    idle(2);
    pop_chk("t3 data", 8'h81);

    // Framing error followed by a break-length low line
    send_frame(8'h3C, 1'b0, 30);
    chk("t4 frame_err", frame_err, 1);
    chk("t4 no push", rx_valid, 0);
    idle(4);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("t4 frame_err cleared", frame_err, 0);
    send_frame(8'h3C, 1'b1, 0);
    idle(2);
    pop_chk("t4 good frame", 8'h3C);

    // Push and pop in the same cycle, then pop while empty
    send_frame(8'h11, 1'b1, 0);
    idle(2);
    pe = cyc + 1 + LAT;
    fork
      send_frame(8'h22, 1'b1, 0);
      begin
        wait_cyc(pe - 1);
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
        chk("t5 data", rd_data, 8'h22);
        chk("t5 valid", rx_valid, 1);
      end
    join
    pop_chk("t5 pop", 8'h22);
    rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
    chk("t5 empty pop valid", rx_valid, 0);
    chk("t5 empty pop data", rd_data, 0);
    chk("t5 empty pop flag", overrun, 0);

    // Reset in the middle of a frame
    send_frame(8'h99, 1'b1, 0);
    idle(3);
    ab = 8'hC5;
    uart_rx = 1'b0; repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin uart_rx = ab[i]; repeat (CPB) @(negedge clk); end
    uart_rx = ab[4]; repeat (CPB/2) @(negedge clk);
    rst = 1'b1; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6 rst valid", rx_valid, 0);
    chk("t6 rst data", rd_data, 0);
    chk("t6 rst overrun", overrun, 0);
    chk("t6 rst frame_err", frame_err, 0);
    rst = 1'b0;
    idle(10);
    send_frame(8'h5A, 1'b1, 0);
    idle(2);
    pop_chk("t6 data", 8'h5A);

    // Random traffic with random reads and clears
    rnd_on = 1'b1;
    repeat (40) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 7) != 0);
      send_frame(rb, rs, $urandom_range(0, 3));
      idle(rs ? $urandom_range(0, 12) : $urandom_range(2, 12));
    end
    rnd_on = 1'b0;
    rd_en = 1'b0; clr_err = 1'b0;
    idle(3);
    repeat (DEPTH) begin rd_en = 1'b1; @(negedge clk); rd_en = 1'b0; end
    idle(2);
    chk("final drained", rx_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
